// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with one registered output stage and a full flag set.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 9, busy).
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             err_flag,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  logic             accept_s;
  logic             out_free_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_lo_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s, z_s, n_s, v_s, e_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             carry_r, zero_r, neg_r, ovf_r, err_r;

  assign out_free_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;

  // Single-cycle datapath and flags, evaluated on the operands being offered
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    sh_s   = b[SHW-1:0];
    res_s  = '0;
    c_s    = 1'b0;
    v_s    = 1'b0;
    e_s    = 1'b0;
    z_s    = 1'b0;
    n_s    = 1'b0;
    case (op_code)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_s = (op_code == OP_SUB) ? diff_s[WIDTH-1:0] : '0;
        c_s   = diff_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_XOR: res_s = a ^ b;
      OP_SHL: res_s = a << sh_s;
      OP_SHR: res_s = a >> sh_s;
      OP_ASR: res_s = $signed(a) >>> sh_s;
`ifdef ALU_MUL_EN
      OP_MUL: res_s = '0;
`endif
      default: e_s = 1'b1;
    endcase
    // CMP discards its difference but still reports equality and the sign of a-b
    if (op_code == OP_CMP) begin
      z_s = (a == b);
      n_s = diff_s[WIDTH-1];
    end else if (e_s) begin
      z_s = 1'b0;
      n_s = 1'b0;
    end else begin
      z_s = (res_s == '0);
      n_s = res_s[WIDTH-1];
    end
  end

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [SHW-1:0]       cnt_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [2*WIDTH-1:0]   prod_nxt_s;
  logic [WIDTH:0]       psum_s;

  assign is_mul_s = (op_code == OP_MUL);
  assign busy     = (state_r == S_MUL);
  assign in_ready = (state_r == S_IDLE) && out_free_s;

  // Shift-add step: upper half accumulates the multiplicand, multiplier shifts out below
  always_comb begin
    psum_s     = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_nxt_s = {psum_s, prod_r[WIDTH-1:1]};
    mul_done_s = (state_r == S_MUL) && (cnt_r == SHW'(WIDTH-1));
    mul_lo_s   = prod_nxt_s[WIDTH-1:0];
    mul_hi_s   = prod_nxt_s[2*WIDTH-1:WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && is_mul_s) state_nxt_s = S_MUL;
        else                      state_nxt_s = S_IDLE;
      end
      S_MUL: begin
        if (mul_done_s) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_MUL;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Multiplier operand, partial product and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= '0;
      prod_r  <= '0;
      cnt_r   <= '0;
    end else if (accept_s && is_mul_s) begin
      mcand_r <= a;
      prod_r  <= {{WIDTH{1'b0}}, b};
      cnt_r   <= '0;
    end else if (state_r == S_MUL) begin
      prod_r  <= prod_nxt_s;
      cnt_r   <= cnt_r + SHW'(1);
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_lo_s   = '0;
  assign mul_hi_s   = '0;
  assign busy       = 1'b0;
  assign in_ready   = out_free_s;
`endif

  // Output stage: load on single-cycle accept or multiply completion, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      result_hi_r <= '0;
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid_r <= 1'b1;
      result_r    <= res_s;
      result_hi_r <= '0;
      carry_r     <= c_s;
      zero_r      <= z_s;
      neg_r       <= n_s;
      ovf_r       <= v_s;
      err_r       <= e_s;
    end else if (mul_done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= mul_lo_s;
      result_hi_r <= mul_hi_s;
      carry_r     <= (mul_hi_s != '0);
      zero_r      <= (mul_lo_s == '0) && (mul_hi_s == '0);
      neg_r       <= mul_lo_s[WIDTH-1];
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign result     = result_r;
  assign result_hi  = result_hi_r;
  assign carry_flag = carry_r;
  assign zero_flag  = zero_r;
  assign neg_flag   = neg_r;
  assign ovf_flag   = ovf_r;
  assign err_flag   = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases plus randomized traffic vs. an arithmetic model.
module tb_alu_pipe;
  localparam int W   = 8;
  localparam int SHW = $clog2(W);

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic c;
    logic z;
    logic n;
    logic v;
    logic e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op_code = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry_flag, zero_flag, neg_flag, ovf_flag, err_flag, busy;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .ovf_flag(ovf_flag),
    .err_flag(err_flag), .busy(busy)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   cyc = 0;
  exp_t snap;
  exp_t got;
  exp_t want;

  always @(posedge clk) cyc++;

  // Reference model: plain integer arithmetic on the opcode rules
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [3:0] mop);
    exp_t   e;
    longint m, ua, ub, sa, sb, full, lo, hi, sh, s;
    bit     ill;
    m    = longint'(1) << W;
    ua   = longint'(ma);
    ub   = longint'(mb);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    sh   = ub % (longint'(1) << SHW);
    full = 0; hi = 0; s = 0; ill = 1'b0; e = '0;
    case (mop)
      4'd0: begin full = ua + ub; s = sa + sb; e.c = (full >= m); end
      4'd1, 4'd8: begin full = ua - ub; s = sa - sb; e.c = (ua < ub); end
      4'd2: full = ua & ub;
      4'd3: full = ua | ub;
      4'd4: full = ua ^ ub;
      4'd5: full = ua << sh;
      4'd6: full = ua >> sh;
      4'd7: full = sa >>> sh;
`ifdef ALU_MUL_EN
      4'd9: begin full = ua * ub; hi = full / m; e.c = (hi != 0); end
`endif
      default: ill = 1'b1;
    endcase
    lo = ((full % m) + m) % m;
    if (ill) begin
      e   = '0;
      e.e = 1'b1;
    end else begin
      e.v  = (mop == 4'd0 || mop == 4'd1 || mop == 4'd8) && (s > m / 2 - 1 || s < -(m / 2));
      e.hi = hi[W-1:0];
      e.n  = lo[W-1];
      if (mop == 4'd8) begin
        e.r = '0;
        e.z = (ua == ub);
      end else begin
        e.r = lo[W-1:0];
        e.z = (lo == 0) && (hi == 0);
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every presented result with the scoreboard head, pop on handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      got = {result, result_hi, carry_flag, zero_flag, neg_flag, ovf_flag, err_flag};
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got r=%0h hi=%0h with nothing pending", result, result_hi);
      end else begin
        want = q[0];
        if (got !== want) begin
          n_bad++;
          $display("FAIL scoreboard: got r=%0h hi=%0h c%0b z%0b n%0b v%0b e%0b, expected r=%0h hi=%0h c%0b z%0b n%0b v%0b e%0b",
                   got.r, got.hi, got.c, got.z, got.n, got.v, got.e,
                   want.r, want.hi, want.c, want.z, want.n, want.v, want.e);
        end
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
  end

  // Offer one operation and hold it until accepted (called and returns at posedge+1)
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [3:0] top);
    bit done = 1'b0;
    in_valid = 1'b1; a = ta; b = tbv; op_code = top;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(ta, tbv, top));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("issue_accepted", longint'(done), 1);
  endtask

  // Measure negedges after the accept edge until out_valid; optionally check busy meanwhile
  task automatic wait_valid(input string name, input int exp_lat, input bit chk_busy);
    int lat = -1;
    for (int j = 0; j < 4 * W && lat < 0; j++) begin
      @(negedge clk);
      if (out_valid) begin
        lat  = j;
        snap = {result, result_hi, carry_flag, zero_flag, neg_flag, ovf_flag, err_flag};
      end else if (chk_busy) begin
        check({name, "_busy"}, longint'(busy), 1);
        check({name, "_in_ready_low"}, longint'(in_ready), 0);
      end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, longint'(lat), longint'(exp_lat));
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", longint'(q.size()), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 8'h00;
      1: v = 8'h80;
      2: v = 8'hFF;
      3: v = 8'h7F;
      default: v = 8'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0, seen;

    // Reset with a valid request pending
    in_valid = 1'b1; a = 8'd1; b = 8'd1; op_code = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_result", longint'({result, result_hi}), 0);
    check("rst_flags", longint'({carry_flag, zero_flag, neg_flag, ovf_flag, err_flag, busy}), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", longint'(in_ready), 1);
    check("post_rst_out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;

    issue(8'd200, 8'd100, 4'd0);
    wait_valid("add", 0, 1'b0);
    check("add_result", longint'(snap.r), 44);
    check("add_flags_cvz", longint'({snap.c, snap.v, snap.z}), 3'b100);

    issue(8'd5, 8'd7, 4'd1);
    wait_valid("sub", 0, 1'b0);
    check("sub_result", longint'(snap.r), 254);
    check("sub_flags_cnv", longint'({snap.c, snap.n, snap.v}), 3'b110);

    issue(8'h80, 8'h01, 4'd8);
    wait_valid("cmp_ovf", 0, 1'b0);
    check("cmp_result", longint'(snap.r), 0);
    check("cmp_flags_vz", longint'({snap.v, snap.z}), 2'b10);

    issue(8'd9, 8'd9, 4'd8);
    wait_valid("cmp_eq", 0, 1'b0);
    check("cmp_eq_zero", longint'(snap.z), 1);

    issue(8'd33, 8'd44, 4'd12);
    wait_valid("illegal", 0, 1'b0);
    check("illegal_err", longint'(snap.e), 1);
    check("illegal_result", longint'(snap.r), 0);

`ifdef ALU_MUL_EN
    issue(8'd15, 8'd17, 4'd9);
    wait_valid("mul", W, 1'b1);
    check("mul_lo", longint'(snap.r), 8'hFF);
    check("mul_hi_carry", longint'({snap.hi, snap.c}), 0);
    issue(8'd255, 8'd255, 4'd9);
    wait_valid("mul_max", W, 1'b1);
    check("mul_max_hi", longint'(snap.hi), 8'hFE);
    check("mul_max_lo_carry", longint'({snap.r, snap.c}), {8'h01, 1'b1});
`else
    issue(8'd15, 8'd17, 4'd9);
    wait_valid("mul_disabled", 0, 1'b0);
    check("mul_disabled_err", longint'({snap.e, snap.r}), {1'b1, 8'h00});
`endif

    // Back-to-back single-cycle ops, one accept per clock
    c0 = cyc;
    issue(8'd1, 8'd2, 4'd0);
    issue(8'hF0, 8'h0F, 4'd3);
    issue(8'h81, 8'd3, 4'd7);
    issue(8'h81, 8'd3, 4'd6);
    check("b2b_cycles", longint'(cyc - c0), 4);
    drain();

    // Backpressure: first result held while the second waits
    out_ready = 1'b0;
    issue(8'd1, 8'd1, 4'd0);
    n0 = n_out;
    fork
      issue(8'hF0, 8'hFF, 4'd4);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_held_valid", longint'(out_valid), 1);
          check("bp_held_result", longint'(result), 2);
          check("bp_in_ready_low", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", longint'(n_out - n0), 2);

    // Reset pulsed while an operation is in flight
`ifdef ALU_MUL_EN
    issue(8'd77, 8'd91, 4'd9);
`else
    out_ready = 1'b0;
    issue(8'd77, 8'd91, 4'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_outputs", longint'({result, result_hi, carry_flag, zero_flag, neg_flag, ovf_flag, err_flag, busy}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (2 * W + 2) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_result", longint'(seen), 0);
    check("abort_in_ready", longint'(in_ready), 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      op_code   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(model(a, b, op_code));
      @(posedge clk); #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
